// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multi-cycle main controller and the datapath it steers.
//   master : the controller (consumes start/opcode/mem_ready, drives controls)
//   slave  : the datapath / environment (drives start/opcode/mem_ready)
// Signals:
//   start, opcode[5:0], mem_ready          -> controller
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0], state[3:0], halted, illegal, instr_count[CNT_W-1:0]
//                                          <- controller
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, halted, illegal, instr_count
  );

  modport slave (
    output start, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, halted, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multi-cycle MIPS-style processor. Decodes the opcode
// held in the IR into per-cycle datapath controls, stalls on mem_ready, counts
// completed instruction fetches (saturating) and parks in HALT or TRAP.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : multicycle_ctrl_if.master (handshake inputs, control outputs)
// Parameters:
//   HALT_OP : opcode that parks the FSM in HALT
//   CNT_W   : width of the fetch counter (must match the interface CNT_W)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'h3F,
  parameter int         CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13,
    S_TRAP      = 4'd14
  } state_e;

  localparam logic [5:0]       OP_RTYPE = 6'h00;
  localparam logic [5:0]       OP_LW    = 6'h23;
  localparam logic [5:0]       OP_SW    = 6'h2B;
  localparam logic [5:0]       OP_BEQ   = 6'h04;
  localparam logic [5:0]       OP_J     = 6'h02;
  localparam logic [5:0]       OP_ADDI  = 6'h08;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       ir_write_s, mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
  logic       halted_s, illegal_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

  // State and fetch-counter registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore control decode; only FETCH looks at mem_ready for outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_source_s     = 2'b00;
    halted_s        = 1'b0;
    illegal_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
        else           state_d = S_IDLE;
      end
      S_FETCH: begin
        // PC+4 computed every cycle; IR and PC only commit once memory answers.
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          else                  cnt_d = cnt_q;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target precomputed here so BRANCH only needs the compare.
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_RTYPE: state_d = S_R_EXEC;
          OP_LW:    state_d = S_MEM_ADDR;
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_ADDI_EX;
          default: begin
            if (bus.opcode == HALT_OP) state_d = S_HALT;
            else                       state_d = S_TRAP;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_LW) state_d = S_MEM_READ;
        else                     state_d = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
        else               state_d = S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else               state_d = S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
        state_d     = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
        state_d  = S_HALT;
      end
      S_TRAP: begin
        halted_s  = 1'b1;
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
      default: begin
        // Encoding 15 is unreachable in normal operation; treat it as a fault.
        state_d = S_TRAP;
      end
    endcase
  end

  assign bus.pc_write      = pc_write_s;
  assign bus.pc_write_cond = pc_write_cond_s;
  assign bus.i_or_d        = i_or_d_s;
  assign bus.mem_read      = mem_read_s;
  assign bus.mem_write     = mem_write_s;
  assign bus.ir_write      = ir_write_s;
  assign bus.mem_to_reg    = mem_to_reg_s;
  assign bus.reg_dst       = reg_dst_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.pc_source     = pc_source_s;
  assign bus.state         = state_q;
  assign bus.halted        = halted_s;
  assign bus.illegal       = illegal_s;
  assign bus.instr_count   = cnt_q;

endmodule
